// File: rtl/e_mdu_if.sv
// e_mdu_if: operand/opcode bus between the E stage and the multiply/divide unit.
`default_nettype none

interface e_mdu_if;
  logic        E_MDU_start;
  logic [2:0]  E_MDU_op;
  logic [31:0] E_GRF_RD1;
  logic [31:0] E_GRF_RD2;
  logic        E_MDU_busy;
  logic        E_MDU_busy_or_start;
  logic [31:0] E_MDU_HI;
  logic [31:0] E_MDU_LO;

  modport master (
    output E_MDU_start, E_MDU_op, E_GRF_RD1, E_GRF_RD2,
    input  E_MDU_busy, E_MDU_busy_or_start, E_MDU_HI, E_MDU_LO
  );

  modport slave (
    input  E_MDU_start, E_MDU_op, E_GRF_RD1, E_GRF_RD2,
    output E_MDU_busy, E_MDU_busy_or_start, E_MDU_HI, E_MDU_LO
  );
endinterface

`default_nettype wire

// File: rtl/e_mdu.sv
// ---------------------------------------------------------------------------
// e_mdu : execute-stage multiply/divide unit with HI/LO and busy counter
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic  clk,
  input  logic  reset,
  e_mdu_if.slave mdu
);

  localparam int c_max_cycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W        = $clog2(c_max_cycles + 1);

  localparam logic [2:0] c_op_mult  = 3'd1;
  localparam logic [2:0] c_op_multu = 3'd2;
  localparam logic [2:0] c_op_div   = 3'd3;
  localparam logic [2:0] c_op_divu  = 3'd4;
  localparam logic [2:0] c_op_mthi  = 3'd5;
  localparam logic [2:0] c_op_mtlo  = 3'd6;

  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               busy;
  logic [31:0]        hi;
  logic [31:0]        lo;
  logic [31:0]        pend_hi;
  logic [31:0]        pend_lo;

  logic [31:0] a;
  logic [31:0] b;
  assign a = mdu.E_GRF_RD1;
  assign b = mdu.E_GRF_RD2;

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prod_u = {32'd0, a} * {32'd0, b};

  // One unsigned divider serves both forms; signed division works on magnitudes.
  logic        is_signed;
  logic        sa;
  logic        sb;
  logic [31:0] dvd;
  logic [31:0] dvs;
  logic [31:0] uq;
  logic [31:0] ur;
  logic [31:0] quot;
  logic [31:0] rem;

  assign is_signed = (mdu.E_MDU_op == c_op_div);
  assign sa        = is_signed & a[31];
  assign sb        = is_signed & b[31];
  assign dvd       = sa ? (32'd0 - a) : a;
  assign dvs       = (b == 32'd0) ? 32'd1 : (sb ? (32'd0 - b) : b);
  assign uq        = dvd / dvs;
  assign ur        = dvd % dvs;
  assign quot      = (sa ^ sb) ? (32'd0 - uq) : uq;
  assign rem       = sa ? (32'd0 - ur) : ur;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      busy    <= 1'b0;
      hi      <= 32'd0;
      lo      <= 32'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (mdu.E_MDU_start) begin
            case (mdu.E_MDU_op)
              c_op_mult, c_op_multu: begin
                {pend_hi, pend_lo} <= (mdu.E_MDU_op == c_op_mult) ? prod_s : prod_u;
                cnt   <= CNT_W'(MULT_CYCLES);
                state <= BUSY;
                busy  <= 1'b1;
              end
              c_op_div, c_op_divu: begin
                // A zero divisor re-commits the current HI/LO, leaving them unchanged.
                if (b == 32'd0) begin
                  pend_hi <= hi;
                  pend_lo <= lo;
                end else begin
                  pend_hi <= rem;
                  pend_lo <= quot;
                end
                cnt   <= CNT_W'(DIV_CYCLES);
                state <= BUSY;
                busy  <= 1'b1;
              end
              c_op_mthi: hi <= a;
              c_op_mtlo: lo <= a;
              default: ;
            endcase
          end
        end
        BUSY: begin
          if (cnt == CNT_W'(1)) begin
            hi    <= pend_hi;
            lo    <= pend_lo;
            cnt   <= '0;
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign mdu.E_MDU_busy          = busy;
  assign mdu.E_MDU_busy_or_start = busy | (mdu.E_MDU_start &
                                           (mdu.E_MDU_op != 3'd0) & (mdu.E_MDU_op != 3'd7));
  assign mdu.E_MDU_HI            = hi;
  assign mdu.E_MDU_LO            = lo;

endmodule

`default_nettype wire

// File: tb/tb_e_mdu.sv
// tb_e_mdu: directed and randomized checks of e_mdu against a cycle-scheduled model.
`default_nettype none

module tb_e_mdu;
  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  e_mdu_if bus();

  e_mdu #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk   (clk),
    .reset (reset),
    .mdu   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit checking = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an accepted op completes at a scheduled edge number.
  longint      m_edge;
  longint      m_done;
  bit          m_inflight;
  logic [31:0] m_hi, m_lo, m_phi, m_plo;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_edge = 0; m_done = 0; m_inflight = 0;
      m_hi = 0; m_lo = 0; m_phi = 0; m_plo = 0;
    end else begin
      m_edge++;
      if (m_inflight) begin
        if (m_edge == m_done) begin
          m_hi = m_phi; m_lo = m_plo; m_inflight = 0;
        end
      end else if (bus.E_MDU_start) begin
        logic [31:0] x, y;
        longint sx, sy, q, r;
        logic [63:0] p;
        x = bus.E_GRF_RD1; y = bus.E_GRF_RD2;
        sx = longint'($signed(x)); sy = longint'($signed(y));
        case (bus.E_MDU_op)
          3'd1: begin p = 64'(sx * sy); {m_phi, m_plo} = p; m_inflight = 1; m_done = m_edge + MULT_N; end
          3'd2: begin p = {32'd0, x} * {32'd0, y}; {m_phi, m_plo} = p; m_inflight = 1; m_done = m_edge + MULT_N; end
          3'd3, 3'd4: begin
            if (bus.E_MDU_op == 3'd4) begin sx = longint'({32'd0, x}); sy = longint'({32'd0, y}); end
            if (y == 0) begin m_phi = m_hi; m_plo = m_lo; end
            else begin q = sx / sy; r = sx % sy; m_plo = q[31:0]; m_phi = r[31:0]; end
            m_inflight = 1; m_done = m_edge + DIV_N;
          end
          3'd5: m_hi = x;
          3'd6: m_lo = x;
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (checking && !reset) begin
      logic bos;
      bos = m_inflight | (bus.E_MDU_start && bus.E_MDU_op inside {[3'd1:3'd6]});
      check("busy", {31'd0, bus.E_MDU_busy}, {31'd0, m_inflight});
      check("busy_or_start", {31'd0, bus.E_MDU_busy_or_start}, {31'd0, bos});
      check("hi", bus.E_MDU_HI, m_hi);
      check("lo", bus.E_MDU_LO, m_lo);
    end
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    @(posedge clk); #2;
    bus.E_MDU_start = 1'b1; bus.E_MDU_op = op; bus.E_GRF_RD1 = x; bus.E_GRF_RD2 = y;
    @(posedge clk); #2;
    bus.E_MDU_start = 1'b0; bus.E_MDU_op = 3'd0;
  endtask

  task automatic wait_idle(output int nbusy);
    nbusy = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!bus.E_MDU_busy) return;
      nbusy++;
    end
    n_checks++; n_fail++;
    $display("FAIL wait_idle: busy still high after 60 cycles, expected it to fall");
  endtask

  int nb;

  initial begin
    bus.E_MDU_start = 1'b0; bus.E_MDU_op = 3'd0; bus.E_GRF_RD1 = 0; bus.E_GRF_RD2 = 0;
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    @(negedge clk);
    check("reset_busy", {31'd0, bus.E_MDU_busy}, 32'd0);
    check("reset_bos", {31'd0, bus.E_MDU_busy_or_start}, 32'd0);
    check("reset_hi", bus.E_MDU_HI, 32'd0);
    check("reset_lo", bus.E_MDU_LO, 32'd0);
    checking = 1'b1;

    issue(3'd1, 32'hFFFFFFFE, 32'd3);
    wait_idle(nb);
    check("mult_busy_cycles", nb, MULT_N);
    check("mult_hi", bus.E_MDU_HI, 32'hFFFFFFFF);
    check("mult_lo", bus.E_MDU_LO, 32'hFFFFFFFA);

    issue(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_idle(nb);
    check("multu_busy_cycles", nb, MULT_N);
    check("multu_hi", bus.E_MDU_HI, 32'hFFFFFFFE);
    check("multu_lo", bus.E_MDU_LO, 32'h00000001);

    issue(3'd3, 32'hFFFFFFF9, 32'd2);
    wait_idle(nb);
    check("div_busy_cycles", nb, DIV_N);
    check("div_lo", bus.E_MDU_LO, 32'hFFFFFFFD);
    check("div_hi", bus.E_MDU_HI, 32'hFFFFFFFF);

    issue(3'd3, 32'h80000000, 32'hFFFFFFFF);
    wait_idle(nb);
    check("divovf_lo", bus.E_MDU_LO, 32'h80000000);
    check("divovf_hi", bus.E_MDU_HI, 32'h00000000);

    issue(3'd4, 32'd100, 32'd0);
    wait_idle(nb);
    check("divu0_busy_cycles", nb, DIV_N);
    check("divu0_lo", bus.E_MDU_LO, 32'h80000000);
    check("divu0_hi", bus.E_MDU_HI, 32'h00000000);
    issue(3'd5, 32'h1234, 32'd0);
    check("mthi_hi", bus.E_MDU_HI, 32'h1234);
    check("mthi_busy", {31'd0, bus.E_MDU_busy}, 32'd0);

    // divu offered at busy cycle 2 of a mult must be dropped.
    issue(3'd1, 32'd5, 32'd7);
    @(posedge clk); #2;
    bus.E_MDU_start = 1'b1; bus.E_MDU_op = 3'd4; bus.E_GRF_RD1 = 32'd100; bus.E_GRF_RD2 = 32'd7;
    @(posedge clk); #2;
    bus.E_MDU_start = 1'b0; bus.E_MDU_op = 3'd0;
    wait_idle(nb);
    check("ignored_busy_cycles", nb, MULT_N - 2);
    check("ignored_hi", bus.E_MDU_HI, 32'd0);
    check("ignored_lo", bus.E_MDU_LO, 32'd35);

    issue(3'd3, 32'd50, 32'd7);
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    check("rst_mid_busy", {31'd0, bus.E_MDU_busy}, 32'd0);
    check("rst_mid_hi", bus.E_MDU_HI, 32'd0);
    check("rst_mid_lo", bus.E_MDU_LO, 32'd0);
    @(negedge clk); #1 reset = 1'b0;
    repeat (15) @(negedge clk);
    check("rst_nowrite_hi", bus.E_MDU_HI, 32'd0);
    check("rst_nowrite_lo", bus.E_MDU_LO, 32'd0);
    check("rst_nowrite_busy", {31'd0, bus.E_MDU_busy}, 32'd0);

    for (int i = 0; i < 1500; i++) begin
      @(posedge clk); #2;
      bus.E_MDU_start = ($urandom_range(0, 2) == 0);
      bus.E_MDU_op    = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0: bus.E_GRF_RD1 = 32'h80000000;
        1: bus.E_GRF_RD1 = 32'($urandom_range(0, 200));
        default: bus.E_GRF_RD1 = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: bus.E_GRF_RD2 = 32'd0;
        1: bus.E_GRF_RD2 = 32'hFFFFFFFF;
        2: bus.E_GRF_RD2 = 32'($urandom_range(1, 20));
        default: bus.E_GRF_RD2 = $urandom;
      endcase
    end
    @(posedge clk); #2;
    bus.E_MDU_start = 1'b0;
    wait_idle(nb);
    @(negedge clk);
    checking = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
